audio_level_meter: RTL and testbench

- Inverse of the volume scaler. Takes a stereo 32-bit signed sample stream and measures its amplitude, where the scaler applies an amplitude.
- Produces a 2-bit level code in the same encoding as the volume select: 00 silent, 01 up to 1/3 full scale, 10 up to 2/3 full scale, 11 loud.
- Also reports the window peak and a sticky clip flag.
- Sits after the audio codec input path and drives the front-panel level LEDs. Loop recording uses it to detect silence.

---
 rtl/audio_level_meter.sv | 105 ++++++++++
 tb/tb_audio_level_meter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_level_meter.sv
// audio_level_meter: windowed peak-amplitude meter for a stereo 32-bit signed stream
// Ports:
//   clk, reset              - system clock, synchronous active-high reset
//   left/right_channel_audio_in - signed samples, taken on edges where audio_in_valid is high
//   clip_clear              - clears the sticky clip flag (a clipping sample on the same edge wins)
//   level                   - 2-bit quantised window peak with hold/decay (00 silent .. 11 loud)
//   level_valid             - one-cycle pulse in the cycle after a window closes
//   peak                    - unsigned magnitude peak of the last completed window
//   clip                    - sticky flag, set by any sample of magnitude 7FFF_FFFF
module audio_level_meter #(
    parameter int          WINDOW       = 1024,
    parameter int          HOLD_WINDOWS = 4,
    parameter logic [31:0] T1           = 32'h0100_0000,
    parameter logic [31:0] T2           = 32'h2AAA_AAAA,
    parameter logic [31:0] T3           = 32'h5555_5555
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    input  logic        audio_in_valid,
    input  logic        clip_clear,
    output logic [1:0]  level,
    output logic        level_valid,
    output logic [31:0] peak,
    output logic        clip
);
    localparam int            CW   = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int            HW   = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
    localparam logic [HW-1:0] HOLD = HW'(HOLD_WINDOWS);
    localparam logic [31:0]   FULL = 32'h7FFF_FFFF;

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_run;
    logic [HW-1:0] r_hold;
    logic [1:0]    r_level;
    logic          r_valid;
    logic [31:0]   r_peak;
    logic          r_clip;

    logic [31:0]   w_abs_l;
    logic [31:0]   w_abs_r;
    logic [31:0]   w_mag;
    logic [31:0]   w_pk;
    logic [1:0]    w_q;
    logic          w_last;

    // The most negative code has no positive twin, so it saturates to full scale.
    function automatic logic [31:0] f_abs(input logic [31:0] x);
        return x[31] ? ((x == 32'h8000_0000) ? FULL : -x) : x;
    endfunction

    assign w_abs_l = f_abs(left_channel_audio_in);
    assign w_abs_r = f_abs(right_channel_audio_in);
    assign w_mag   = (w_abs_l > w_abs_r) ? w_abs_l : w_abs_r;
    // Running peak including the current sample; on the closing edge this is the window result.
    assign w_pk    = (w_mag > r_run) ? w_mag : r_run;
    assign w_q     = (w_pk < T1) ? 2'd0 : (w_pk < T2) ? 2'd1 : (w_pk < T3) ? 2'd2 : 2'd3;
    assign w_last  = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_run   <= '0;
            r_hold  <= '0;
            r_level <= 2'd0;
            r_valid <= 1'b0;
            r_peak  <= '0;
            r_clip  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (audio_in_valid && w_mag == FULL)
                r_clip <= 1'b1;
            else if (clip_clear)
                r_clip <= 1'b0;
            if (audio_in_valid) begin
                if (w_last) begin
                    r_cnt   <= '0;
                    r_run   <= '0;
                    r_peak  <= w_pk;
                    r_valid <= 1'b1;
                    // Rise immediately; fall only after the hold expires, one step per window.
                    // q < level here implies level >= 1, so the decrement cannot underflow.
                    if (w_q >= r_level) begin
                        r_level <= w_q;
                        r_hold  <= HOLD;
                    end else if (r_hold != '0) begin
                        r_hold  <= r_hold - HW'(1);
                    end else begin
                        r_level <= r_level - 2'd1;
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                    r_run <= w_pk;
                end
            end
        end
    end

    assign level       = r_level;
    assign level_valid = r_valid;
    assign peak        = r_peak;
    assign clip        = r_clip;
endmodule

// File: tb/tb_audio_level_meter.sv
// tb_audio_level_meter: table-driven + scoreboard bench for audio_level_meter (WINDOW=4, HOLD_WINDOWS=2)
module tb_audio_level_meter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] l_in = '0;
    logic [31:0] r_in = '0;
    logic        valid = 1'b0;
    logic        cc = 1'b0;
    logic [1:0]  level;
    logic        level_valid;
    logic [31:0] peak;
    logic        clip;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic [31:0] l;
        logic [31:0] r;
        logic [1:0]  lv;
        logic [31:0] pk;
        logic        clip;
    } vec_t;

    typedef struct {
        logic [1:0]  lv;
        logic [31:0] pk;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    audio_level_meter #(.WINDOW(4), .HOLD_WINDOWS(2)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .left_channel_audio_in  (l_in),
        .right_channel_audio_in (r_in),
        .audio_in_valid         (valid),
        .clip_clear             (cc),
        .level                  (level),
        .level_valid            (level_valid),
        .peak                   (peak),
        .clip                   (clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every level_valid pulse must match the oldest pushed expectation.
    exp_t e;
    always @(negedge clk) begin
        if (level_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got level=%0d peak=%h expected no pulse", level, peak);
            end else begin
                e = sb.pop_front();
                chk("pulse_level", 32'(level), 32'(e.lv));
                chk("pulse_peak", peak, e.pk);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            l_in  = $urandom;
            r_in  = $urandom;
            valid = 1'($urandom);
            cc    = 1'($urandom);
            step();
        end
        reset = 1'b0;
        valid = 1'b0;
        cc    = 1'b0;
        l_in  = '0;
        r_in  = '0;
    endtask

    task automatic win(input logic [31:0] l, input logic [31:0] r, input logic [1:0] lv, input logic [31:0] pk);
        for (int i = 0; i < 4; i++) begin
            l_in  = l;
            r_in  = r;
            valid = 1'b1;
            if (i == 3) sb.push_back('{lv, pk});
            step();
            chk("pulse_timing", 32'(level_valid), 32'(i == 3));
        end
        valid = 1'b0;
        step();
        chk("pulse_drained", sb.size(), 0);
    endtask

    function automatic vec_t mk(input logic rst, input logic [31:0] l, input logic [31:0] r,
                                input logic [1:0] lv, input logic [31:0] pk, input logic c);
        vec_t v;
        v.rst = rst; v.l = l; v.r = r; v.lv = lv; v.pk = pk; v.clip = c;
        return v;
    endfunction

    initial begin
        tbl.push_back(mk(1, 32'h0000_1000, 32'h0000_1000, 2'd0, 32'h0000_1000, 0));
        tbl.push_back(mk(1, 32'h1000_0000, 32'h1000_0000, 2'd1, 32'h1000_0000, 0));
        tbl.push_back(mk(1, 32'h4000_0000, 32'h4000_0000, 2'd2, 32'h4000_0000, 0));
        tbl.push_back(mk(1, 32'h6000_0000, 32'h6000_0000, 2'd3, 32'h6000_0000, 0));
        tbl.push_back(mk(1, 32'h8000_0000, 32'h0000_0000, 2'd3, 32'h7FFF_FFFF, 1));
        tbl.push_back(mk(1, 32'h00FF_FFFF, 32'h0000_0000, 2'd0, 32'h00FF_FFFF, 0));
        tbl.push_back(mk(1, 32'h0100_0000, 32'h0000_0000, 2'd1, 32'h0100_0000, 0));
        tbl.push_back(mk(1, 32'hD555_5556, 32'h0000_0000, 2'd2, 32'h2AAA_AAAA, 0));
        tbl.push_back(mk(1, 32'h5555_5555, 32'h0000_0000, 2'd3, 32'h5555_5555, 0));
        tbl.push_back(mk(1, 32'h0000_0100, 32'hC000_0000, 2'd2, 32'h4000_0000, 0));
        tbl.push_back(mk(1, 32'h6000_0000, 32'h6000_0000, 2'd3, 32'h6000_0000, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 2'd3, 32'h0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 2'd3, 32'h0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 2'd2, 32'h0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 2'd1, 32'h0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 2'd0, 32'h0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 2'd0, 32'h0, 0));

        do_reset();
        chk("rst_level", 32'(level), 0);
        chk("rst_peak", peak, 0);
        chk("rst_clip", 32'(clip), 0);
        chk("rst_valid", 32'(level_valid), 0);
        for (int i = 0; i < 10; i++) begin
            l_in = $urandom;
            r_in = $urandom;
            step();
            chk("idle_no_pulse", 32'(level_valid), 0);
        end

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            win(tbl[i].l, tbl[i].r, tbl[i].lv, tbl[i].pk);
            chk("tbl_level", 32'(level), 32'(tbl[i].lv));
            chk("tbl_peak", peak, tbl[i].pk);
            chk("tbl_clip", 32'(clip), 32'(tbl[i].clip));
        end

        do_reset();
        win(32'h8000_0000, 32'h0, 2'd3, 32'h7FFF_FFFF);
        chk("clip_set", 32'(clip), 1);
        l_in  = 32'h8000_0001;
        valid = 1'b1;
        cc    = 1'b1;
        step();
        chk("clip_set_wins", 32'(clip), 1);
        valid = 1'b0;
        step();
        chk("clip_cleared", 32'(clip), 0);
        cc = 1'b0;
        step();
        chk("clip_stays_clear", 32'(clip), 0);

        do_reset();
        for (int c = 0; c <= 10; c++) begin
            valid = (c == 0 || c == 3 || c == 4 || c == 9);
            l_in  = (c == 9) ? 32'h3000_0000 : 32'h0000_0100;
            r_in  = 32'h0000_0080;
            if (c == 9) sb.push_back('{2'd2, 32'h3000_0000});
            step();
            chk("irr_pulse", 32'(level_valid), 32'(c == 9));
        end
        chk("irr_level", 32'(level), 2);

        do_reset();
        for (int c = 0; c <= 10; c++) begin
            reset = (c == 5);
            valid = (c == 0 || c == 3 || c == 4 || c == 9);
            l_in  = (c == 9) ? 32'h3000_0000 : 32'h0000_0100;
            r_in  = 32'h0000_0080;
            step();
            chk("irr_rst_no_pulse", 32'(level_valid), 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            l_in  = 32'h0000_0100;
            if (i == 2) sb.push_back('{2'd2, 32'h3000_0000});
            step();
            chk("irr_restart_pulse", 32'(level_valid), 32'(i == 2));
        end
        valid = 1'b0;
        step();
        chk("irr_restart_level", 32'(level), 2);
        chk("final_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
